// File: rtl/minibus_arbiter_pkg.sv
// Shared types and the round-robin pick helper for the minibus arbiter and interconnect.
package minibus_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } arb_state_t;

    // Access width, funct3-style encoding shared with the core.
    typedef enum logic [1:0] {
        WIDTH_BYTE = 2'd0,
        WIDTH_HALF = 2'd1,
        WIDTH_WORD = 2'd2
    } mb_width_t;

    localparam int MAX_CH = 8;

    // First pending index at or after ptr, searching modulo nch (up to MAX_CH channels).
    function automatic logic [2:0] rr_pick(input logic [7:0] pending,
                                           input logic [2:0] ptr,
                                           input int unsigned nch);
        logic [2:0] pick;
        logic       found;
        int         idx;
        pick  = 3'd0;
        found = 1'b0;
        for (int i = 0; i < MAX_CH; i++) begin
            idx = (int'(ptr) + i) % int'(nch);
            if (!found && (i < int'(nch)) && pending[idx]) begin
                pick  = 3'(idx);
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/minibus_arbiter_if.sv
// Minibus master/slave handshake bundle: request fields, ack/err and read data.
interface minibus_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          ren;
    logic          wen;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [1:0]    width;
    logic          ack;
    logic          err;
    logic [DW-1:0] rdata;

    modport master (output ren, wen, addr, wdata, width, input ack, err, rdata);
    modport slave  (input ren, wen, addr, wdata, width, output ack, err, rdata);
endinterface

// File: rtl/minibus_arbiter_rr_picker.sv
// Combinational grant picker: fixed (lowest index) or round-robin from a pointer.
module minibus_arbiter_rr_picker
    import minibus_arbiter_pkg::*;
#(
    parameter int NCH = 2,
    parameter int IW  = 1
) (
    input  logic [NCH-1:0] pending,
    input  logic [IW-1:0]  ptr,
    input  logic           rr_mode,
    output logic           valid,
    output logic [IW-1:0]  idx
);
    logic [2:0] pick_s;
    logic [2:0] ptr_s;

    // Fixed priority is simply a round-robin search anchored at channel 0.
    always_comb begin
        if (rr_mode) begin
            ptr_s = 3'(ptr);
        end else begin
            ptr_s = 3'd0;
        end
        pick_s = rr_pick(8'(pending), ptr_s, NCH);
    end

    assign valid = |pending;
    assign idx   = IW'(pick_s);

endmodule

// File: rtl/minibus_arbiter.sv
// N-channel minibus arbiter: latches one granted command, waits for ack or timeout, pulses hit/err.
module minibus_arbiter
    import minibus_arbiter_pkg::*;
#(
    parameter int NCH     = 2,
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int RR      = 0,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NCH-1:0]    ch_ren,
    input  logic [NCH-1:0]    ch_wen,
    input  logic [NCH*AW-1:0] ch_addr,
    input  logic [NCH*DW-1:0] ch_wdata,
    input  logic [NCH*2-1:0]  ch_width,
    output logic [NCH-1:0]    ch_hit,
    output logic [NCH-1:0]    ch_err,
    output logic [DW-1:0]     ch_rdata,
    minibus_arbiter_if.master bus
);
    localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

    localparam logic [1:0] ST_IDLE = IDLE;
    localparam logic [1:0] ST_REQ  = REQ;
    localparam logic [1:0] ST_RESP = RESP;

    logic [1:0]    state_r;
    logic [IW-1:0] grant_r;
    logic [IW-1:0] rr_ptr_r;
    logic [CW-1:0] cnt_r;
    logic          bus_ren_r;
    logic          bus_wen_r;
    logic [AW-1:0] bus_addr_r;
    logic [DW-1:0] bus_wdata_r;
    logic [1:0]    bus_width_r;
    logic [NCH-1:0] hit_r;
    logic [NCH-1:0] err_r;
    logic [DW-1:0] rdata_r;

    logic           pick_valid_s;
    logic [IW-1:0]  pick_idx_s;
    logic [NCH-1:0] pending_s;
    logic           sel_wen_s;
    logic [AW-1:0]  sel_addr_s;
    logic [DW-1:0]  sel_wdata_s;
    logic [1:0]     sel_width_s;
    logic [NCH-1:0] grant_oh_s;
    logic [IW-1:0]  ptr_next_s;
    logic           timeout_s;

    assign pending_s = ch_ren | ch_wen;

    minibus_arbiter_rr_picker #(
        .NCH (NCH),
        .IW  (IW)
    ) u_picker (
        .pending (pending_s),
        .ptr     (rr_ptr_r),
        .rr_mode (RR != 0),
        .valid   (pick_valid_s),
        .idx     (pick_idx_s)
    );

    // Select the candidate channel's command and derive grant/pointer helpers.
    always_comb begin
        sel_wen_s   = ch_wen[pick_idx_s];
        sel_addr_s  = ch_addr[int'(pick_idx_s)*AW +: AW];
        sel_wdata_s = ch_wdata[int'(pick_idx_s)*DW +: DW];
        sel_width_s = ch_width[int'(pick_idx_s)*2 +: 2];
        for (int i = 0; i < NCH; i++) begin
            grant_oh_s[i] = (grant_r == IW'(i));
        end
        if (grant_r == IW'(NCH - 1)) begin
            ptr_next_s = '0;
        end else begin
            ptr_next_s = grant_r + IW'(1);
        end
        timeout_s = (TIMEOUT != 0) && (cnt_r == TO_LAST);
    end

    // Transaction FSM; bus request, response pulses and read data are all registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            grant_r     <= '0;
            rr_ptr_r    <= '0;
            cnt_r       <= '0;
            bus_ren_r   <= 1'b0;
            bus_wen_r   <= 1'b0;
            bus_addr_r  <= '0;
            bus_wdata_r <= '0;
            bus_width_r <= 2'd0;
            hit_r       <= '0;
            err_r       <= '0;
            rdata_r     <= '0;
        end else begin
            hit_r <= '0;
            err_r <= '0;
            case (state_r)
                ST_IDLE: begin
                    if (pick_valid_s) begin
                        bus_wen_r   <= sel_wen_s;
                        bus_ren_r   <= ~sel_wen_s;
                        bus_addr_r  <= sel_addr_s;
                        bus_wdata_r <= sel_wdata_s;
                        bus_width_r <= sel_width_s;
                        grant_r     <= pick_idx_s;
                        cnt_r       <= '0;
                        state_r     <= ST_REQ;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_REQ: begin
                    cnt_r <= cnt_r + CW'(1);
                    if (bus.ack) begin
                        rdata_r   <= bus.rdata;
                        bus_ren_r <= 1'b0;
                        bus_wen_r <= 1'b0;
                        if (bus.err) begin
                            err_r <= grant_oh_s;
                        end else begin
                            hit_r <= grant_oh_s;
                        end
                        state_r <= ST_RESP;
                    end else if (timeout_s) begin
                        bus_ren_r <= 1'b0;
                        bus_wen_r <= 1'b0;
                        err_r     <= grant_oh_s;
                        state_r   <= ST_RESP;
                    end else begin
                        state_r <= ST_REQ;
                    end
                end
                ST_RESP: begin
                    if (RR != 0) begin
                        rr_ptr_r <= ptr_next_s;
                    end else begin
                        rr_ptr_r <= '0;
                    end
                    cnt_r   <= '0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    bus_ren_r <= 1'b0;
                    bus_wen_r <= 1'b0;
                    state_r   <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.ren   = bus_ren_r;
    assign bus.wen   = bus_wen_r;
    assign bus.addr  = bus_addr_r;
    assign bus.wdata = bus_wdata_r;
    assign bus.width = bus_width_r;
    assign ch_hit    = hit_r;
    assign ch_err    = err_r;
    assign ch_rdata  = rdata_r;

endmodule

// File: tb/tb_minibus_arbiter.sv
// Directed bench: a fixed-priority and a round-robin arbiter share one set of channel inputs.
module tb_minibus_arbiter;
    import minibus_arbiter_pkg::*;

    localparam int NCH = 3;
    localparam int AW  = 32;
    localparam int DW  = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst;
    logic [NCH-1:0]    ch_ren;
    logic [NCH-1:0]    ch_wen;
    logic [NCH*AW-1:0] ch_addr;
    logic [NCH*DW-1:0] ch_wdata;
    logic [NCH*2-1:0]  ch_width;
    logic [NCH-1:0]    hit_a, err_a, hit_b, err_b;
    logic [DW-1:0]     rdata_a, rdata_b;
    logic              auto_a, man_ack, man_err;
    logic [DW-1:0]     man_rdata;

    int checks = 0;
    int errors = 0;

    minibus_arbiter_if #(.AW(AW), .DW(DW)) bus_a ();
    minibus_arbiter_if #(.AW(AW), .DW(DW)) bus_b ();

    assign bus_a.ack   = auto_a ? (bus_a.ren | bus_a.wen) : man_ack;
    assign bus_a.err   = auto_a ? 1'b0 : man_err;
    assign bus_a.rdata = man_rdata;
    assign bus_b.ack   = bus_b.ren | bus_b.wen;
    assign bus_b.err   = 1'b0;
    assign bus_b.rdata = 32'h0000_0000;

    minibus_arbiter #(.NCH(NCH), .AW(AW), .DW(DW), .RR(0), .TIMEOUT(8)) dut_fx (
        .clk(clk), .rst(rst), .ch_ren(ch_ren), .ch_wen(ch_wen), .ch_addr(ch_addr),
        .ch_wdata(ch_wdata), .ch_width(ch_width), .ch_hit(hit_a), .ch_err(err_a),
        .ch_rdata(rdata_a), .bus(bus_a)
    );

    minibus_arbiter #(.NCH(NCH), .AW(AW), .DW(DW), .RR(1), .TIMEOUT(8)) dut_rr (
        .clk(clk), .rst(rst), .ch_ren(ch_ren), .ch_wen(ch_wen), .ch_addr(ch_addr),
        .ch_wdata(ch_wdata), .ch_width(ch_width), .ch_hit(hit_b), .ch_err(err_b),
        .ch_rdata(rdata_b), .bus(bus_b)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ch(input int c, input logic [31:0] addr, input logic [31:0] wdata);
        ch_addr[c*AW +: AW]  = addr;
        ch_wdata[c*DW +: DW] = wdata;
        ch_width[c*2 +: 2]   = WIDTH_WORD;
    endtask

    function automatic int oh2idx(input logic [2:0] oh);
        case (oh)
            3'b001:  return 0;
            3'b010:  return 1;
            3'b100:  return 2;
            default: return 7;
        endcase
    endfunction

    int n;
    int na, nb;
    int ga[4];
    int gb[4];
    int exp_rr[4] = '{0, 1, 2, 0};
    logic [NCH-1:0] seen;

    initial begin
        rst = 1'b1; ch_ren = '0; ch_wen = '0; ch_addr = '0; ch_wdata = '0; ch_width = '0;
        auto_a = 1'b0; man_ack = 1'b0; man_err = 1'b0; man_rdata = '0;
        tick(); tick();
        check("rst_ren",   bus_a.ren,   1'b0);
        check("rst_wen",   bus_a.wen,   1'b0);
        check("rst_addr",  bus_a.addr,  32'h0);
        check("rst_width", bus_a.width, 2'd0);
        check("rst_pulse", {hit_a, err_a, hit_b, err_b}, 12'h000);
        check("rst_rdata", rdata_a,     32'h0);
        rst = 1'b0;
        tick();

        // Single read on channel 1, acked two cycles after the request rises.
        set_ch(1, 32'h0000_1000, 32'h0);
        ch_ren = 3'b010;
        tick();
        check("rd_ren",   bus_a.ren,   1'b1);
        check("rd_wen",   bus_a.wen,   1'b0);
        check("rd_addr",  bus_a.addr,  32'h0000_1000);
        check("rd_width", bus_a.width, 2'd2);
        tick();
        check("rd_wait_hit", hit_a, 3'b000);
        man_ack = 1'b1; man_rdata = 32'hDEAD_BEEF;
        tick();
        check("rd_hit",   hit_a,     3'b010);
        check("rd_err",   err_a,     3'b000);
        check("rd_rdata", rdata_a,   32'hDEAD_BEEF);
        check("rd_resp_ren", bus_a.ren, 1'b0);
        man_ack = 1'b0; man_rdata = 32'h0; ch_ren = 3'b000;
        tick();
        check("rd_hit_clr",  hit_a,   3'b000);
        check("rd_rdata_hold", rdata_a, 32'hDEAD_BEEF);
        tick();

        // Write wins over read on the same channel; immediate ack gives hit two edges after request.
        set_ch(0, 32'h0000_0020, 32'h1234_5678);
        ch_ren = 3'b001; ch_wen = 3'b001;
        tick();
        check("wr_wen",   bus_a.wen,   1'b1);
        check("wr_ren",   bus_a.ren,   1'b0);
        check("wr_wdata", bus_a.wdata, 32'h1234_5678);
        check("wr_addr",  bus_a.addr,  32'h0000_0020);
        man_ack = 1'b1;
        tick();
        check("wr_hit", hit_a, 3'b001);
        ch_ren = 3'b000; ch_wen = 3'b000; man_ack = 1'b0;
        tick(); tick();

        // Slave error on channel 2.
        set_ch(2, 32'h0000_0300, 32'h0);
        ch_ren = 3'b100;
        tick();
        man_ack = 1'b1; man_err = 1'b1;
        tick();
        check("serr_err", err_a, 3'b100);
        check("serr_hit", hit_a, 3'b000);
        ch_ren = 3'b000; man_ack = 1'b0; man_err = 1'b0;
        tick(); tick();

        // Requester withdraws and changes address after the grant.
        set_ch(1, 32'h0000_0040, 32'h0);
        ch_ren = 3'b010;
        tick();
        ch_ren = 3'b000;
        set_ch(1, 32'h0000_0080, 32'h0);
        tick();
        check("wd_ren",  bus_a.ren,  1'b1);
        check("wd_addr", bus_a.addr, 32'h0000_0040);
        man_ack = 1'b1; man_rdata = 32'hCAFE_0001;
        tick();
        check("wd_hit",   hit_a,   3'b010);
        check("wd_rdata", rdata_a, 32'hCAFE_0001);
        man_ack = 1'b0;
        tick(); tick();
        check("wd_idle_ren", bus_a.ren, 1'b0);

        // Timeout: no ack, request must stay up for exactly 8 cycles.
        set_ch(2, 32'h0000_0500, 32'h0);
        ch_ren = 3'b100;
        tick();
        n = 0;
        while (bus_a.ren && n < 20) begin
            n++;
            tick();
        end
        check("to_cycles", n, 8);
        check("to_err",    err_a, 3'b100);
        check("to_hit",    hit_a, 3'b000);
        ch_ren = 3'b000;
        tick(); tick();

        // Reset asserted mid-transaction drops the request with no pulse.
        set_ch(0, 32'h0000_0600, 32'h0);
        ch_ren = 3'b001;
        tick();
        check("rq_ren", bus_a.ren, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        check("arst_ren",  bus_a.ren,  1'b0);
        check("arst_addr", bus_a.addr, 32'h0);
        ch_ren = 3'b000; man_ack = 1'b1;
        tick(); tick();
        rst = 1'b0; man_ack = 1'b0;
        seen = '0;
        repeat (4) begin
            tick();
            seen = seen | hit_a | err_a;
        end
        check("arst_nopulse", seen, 3'b000);

        // All three channels held: fixed priority vs round-robin grant order.
        auto_a = 1'b1;
        set_ch(0, 32'h0000_0A00, 32'h0);
        set_ch(1, 32'h0000_0B00, 32'h0);
        set_ch(2, 32'h0000_0C00, 32'h0);
        ch_ren = 3'b111;
        na = 0; nb = 0;
        for (int k = 0; k < 40 && (na < 4 || nb < 4); k++) begin
            tick();
            if (hit_a != 3'b000 && na < 4) begin
                ga[na] = oh2idx(hit_a);
                na++;
            end
            if (hit_b != 3'b000 && nb < 4) begin
                gb[nb] = oh2idx(hit_b);
                nb++;
            end
        end
        check("fx_count", na, 4);
        check("rr_count", nb, 4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("fx_grant%0d", i), ga[i], 0);
            check($sformatf("rr_grant%0d", i), gb[i], exp_rr[i]);
        end
        check("rr_err",   err_b,   3'b000);
        check("rr_rdata", rdata_b, 32'h0);
        ch_ren = 3'b000; auto_a = 1'b0;
        tick(); tick(); tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
